// File: rtl/prim_multi_event_sync_pkg.sv
// Shared types and helpers for the multi-channel event synchronizer.
package prim_multi_event_sync_pkg;

    typedef enum logic [1:0] {
        EdgeRise = 2'd0,
        EdgeFall = 2'd1,
        EdgeBoth = 2'd2,
        EdgeNone = 2'd3
    } edge_mode_e;

    // Clock edges of masking after reset: two synchronizer stages plus level_q.
    localparam int unsigned InitStages = 3;

    function automatic logic edge_sel(edge_mode_e mode, logic rise, logic fall);
        logic sel;
        case (mode)
            EdgeRise: sel = rise;
            EdgeFall: sel = fall;
            EdgeBoth: sel = rise | fall;
            default:  sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/prim_event_cnt.sv
// Per-channel saturating pending-event counter with sticky overflow flag.
module prim_event_cnt #(
    parameter int unsigned CntW = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            ready_i,
    input  logic            ovf_clr_i,
    output logic            valid_o,
    output logic [CntW-1:0] cnt_o,
    output logic            ovf_o
);

    localparam logic [CntW-1:0] CntMax = '1;
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            pop;

    assign valid_o = (cnt_q != '0);
    assign pop     = valid_o & ready_i;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        // Overflow is evaluated after the clear so a same-cycle drop keeps the flag.
        if (push_i && !pop) begin
            if (cnt_q == CntMax) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end else if (!push_i && pop) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

`ifndef SYNTHESIS
    cnt_no_wrap_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (cnt_q == CntMax) |=> (cnt_q >= CntMax - CntOne));
    push_pop_hold_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (push_i && pop) |=> (cnt_q == $past(cnt_q)));
`endif

endmodule

// File: rtl/prim_flop_2sync.sv
// Two-stage synchronizer for asynchronous level inputs.
module prim_flop_2sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] stage_p0;
    logic [Width-1:0] stage_p1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_p0 <= '0;
            stage_p1 <= '0;
        end else begin
            stage_p0 <= d_i;
            stage_p1 <= stage_p0;
        end
    end

    assign q_o = stage_p1;

endmodule

// File: rtl/prim_multi_event_sync.sv
// Multi-channel async event synchronizer with per-channel edge select and
// saturating pending counters drained through valid/ready.
module prim_multi_event_sync
    import prim_multi_event_sync_pkg::*;
#(
    parameter int unsigned         NumCh    = 4,
    parameter int unsigned         CntW     = 4,
    parameter logic [2*NumCh-1:0]  EdgeMode = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumCh-1:0]      async_i,
    output logic [NumCh-1:0]      evt_valid_o,
    input  logic [NumCh-1:0]      evt_ready_i,
    output logic [NumCh*CntW-1:0] evt_cnt_o,
    output logic [NumCh-1:0]      ovf_o,
    input  logic [NumCh-1:0]      ovf_clr_i
);

    logic [NumCh-1:0]      sync;
    logic [NumCh-1:0]      level_q;
    logic [InitStages-1:0] init_q;
    logic                  init_done;
    logic [NumCh-1:0]      rise, fall, edge_det;

    prim_flop_2sync #(
        .Width (NumCh)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (async_i),
        .q_o    (sync)
    );

    // Edges stay masked until the synchronizer and level_q hold real samples,
    // so an input already high at reset release is not counted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
            init_q  <= '0;
        end else begin
            level_q <= sync;
            init_q  <= {init_q[InitStages-2:0], 1'b1};
        end
    end

    assign init_done = init_q[InitStages-1];
    assign rise      = sync & ~level_q;
    assign fall      = ~sync & level_q;

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        assign edge_det[c] = init_done &
            edge_sel(edge_mode_e'(EdgeMode[2*c +: 2]), rise[c], fall[c]);

        prim_event_cnt #(
            .CntW (CntW)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .push_i    (edge_det[c]),
            .ready_i   (evt_ready_i[c]),
            .ovf_clr_i (ovf_clr_i[c]),
            .valid_o   (evt_valid_o[c]),
            .cnt_o     (evt_cnt_o[c*CntW +: CntW]),
            .ovf_o     (ovf_o[c])
        );
    end

endmodule

// File: tb/tb_prim_multi_event_sync.sv
// Self-checking bench: directed vector tables plus a reference-model random run.
module tb_prim_multi_event_sync;

    localparam int unsigned NumCh    = 4;
    localparam int unsigned CntW     = 2;
    // ch0 rise, ch1 both, ch2 rise, ch3 rise
    localparam logic [7:0]  EdgeMode = 8'b00_00_10_00;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] async_in;
    logic [3:0] valid;
    logic [3:0] ready;
    logic [7:0] cnt;
    logic [3:0] ovf;
    logic [3:0] clr;

    prim_multi_event_sync #(
        .NumCh    (NumCh),
        .CntW     (CntW),
        .EdgeMode (EdgeMode)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .async_i     (async_in),
        .evt_valid_o (valid),
        .evt_ready_i (ready),
        .evt_cnt_o   (cnt),
        .ovf_o       (ovf),
        .ovf_clr_i   (clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] r;
        logic [3:0] c;
        logic [7:0] cnt;
        logic [3:0] ovf;
    } vec_t;

    typedef struct {
        logic [7:0] cnt;
        logic [3:0] ovf;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_lvl, m_ovf;
    logic [1:0] m_cnt [4];
    int         m_edges;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_ovf = '0; m_edges = 0;
        for (int c = 0; c < 4; c++) m_cnt[c] = '0;
    endtask

    task automatic model_step(input logic [3:0] a, input logic [3:0] r,
                              input logic [3:0] cl, output exp_t e);
        logic push, pop, rs, fl;
        for (int c = 0; c < 4; c++) begin
            rs = m_s2[c] && !m_lvl[c];
            fl = !m_s2[c] && m_lvl[c];
            case (EdgeMode[2*c +: 2])
                2'd0:    push = rs;
                2'd1:    push = fl;
                2'd2:    push = rs || fl;
                default: push = 1'b0;
            endcase
            if (m_edges < 3) push = 1'b0;
            pop = (m_cnt[c] != 0) && r[c];
            if (cl[c]) m_ovf[c] = 1'b0;
            if (push && !pop) begin
                if (m_cnt[c] == 2'd3) m_ovf[c] = 1'b1;
                else m_cnt[c] = m_cnt[c] + 2'd1;
            end else if (!push && pop) begin
                m_cnt[c] = m_cnt[c] - 2'd1;
            end
        end
        m_lvl = m_s2; m_s2 = m_s1; m_s1 = a;
        m_edges++;
        for (int c = 0; c < 4; c++) e.cnt[2*c +: 2] = m_cnt[c];
        e.ovf = m_ovf;
    endtask

    task automatic compare(input string name);
        exp_t       e;
        logic [3:0] ev;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, cnt=%h ovf=%b", name, cnt, ovf);
            return;
        end
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) ev[c] = (e.cnt[2*c +: 2] != 2'd0);
        n_vec++;
        if (cnt !== e.cnt || valid !== ev || ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL %s #%0d: got cnt=%h valid=%b ovf=%b, want cnt=%h valid=%b ovf=%b",
                     name, n_vec, cnt, valid, ovf, e.cnt, ev, e.ovf);
        end
    endtask

    task automatic step(input logic [3:0] a, input logic [3:0] r, input logic [3:0] cl,
                        input logic use_model, input logic [7:0] ecnt,
                        input logic [3:0] eovf, input string name);
        exp_t e;
        @(negedge clk);
        async_in = a; ready = r; clr = cl;
        if (use_model) begin
            model_step(a, r, cl, e);
        end else begin
            e.cnt = ecnt; e.ovf = eovf;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare(name);
    endtask

    task automatic add(input logic [3:0] a, input logic [3:0] r, input logic [3:0] cl,
                       input logic [7:0] ecnt, input logic [3:0] eovf);
        vec_t v;
        v.a = a; v.r = r; v.c = cl; v.cnt = ecnt; v.ovf = eovf;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) step(tbl[i].a, tbl[i].r, tbl[i].c, 1'b0, tbl[i].cnt, tbl[i].ovf, name);
        tbl.delete();
    endtask

    task automatic check_now(input string name);
        exp_t e;
        e.cnt = '0; e.ovf = '0;
        sb.push_back(e);
        compare(name);
    endtask

    int         hold [4];
    logic [3:0] ra, rr, rc;

    initial begin
        rst_n = 1'b0; async_in = 4'b0001; ready = '0; clr = '0;
        repeat (3) @(negedge clk);
        check_now("reset_state");
        rst_n = 1'b1;

        // High input at release: no event
        for (int i = 0; i < 10; i++) add(4'b0001, 4'b0000, 4'b0000, 8'h00, 4'h0);
        run_table("init_mask");

        // Channel 0 rise, then single pop
        for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 4'b0000, 8'h00, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h00, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h00, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h01, 4'h0);
        add(4'b0001, 4'b0001, 4'b0000, 8'h00, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h00, 4'h0);
        run_table("ch0_rise");

        // Channel 1 both-edge mode, three toggles then drain
        add(4'b0011, 4'b0000, 4'b0000, 8'h00, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h00, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h04, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h04, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h04, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h04, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h08, 4'h0);
        add(4'b0001, 4'b0000, 4'b0000, 8'h08, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h08, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h08, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h0C, 4'h0);
        add(4'b0011, 4'b0010, 4'b0000, 8'h08, 4'h0);
        add(4'b0011, 4'b0010, 4'b0000, 8'h04, 4'h0);
        add(4'b0011, 4'b0010, 4'b0000, 8'h00, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h00, 4'h0);
        run_table("ch1_both");

        // Channel 2 saturation, overflow, clear collision, clear
        for (int k = 0; k < 6; k++) begin
            logic [7:0] c0, c1;
            logic [3:0] o0, o1;
            c0 = (k == 0) ? 8'h10 : (k == 1) ? 8'h20 : 8'h30;
            c1 = (k == 0) ? 8'h00 : (k == 1) ? 8'h10 : (k == 2) ? 8'h20 : 8'h30;
            o0 = (k >= 3) ? 4'b0100 : 4'b0000;
            o1 = (k >= 4) ? 4'b0100 : 4'b0000;
            if (k == 0) c1 = 8'h00;
            add(4'b0111, 4'b0000, 4'b0000, c1, o1);
            add(4'b0111, 4'b0000, 4'b0000, c1, o1);
            add(4'b0011, 4'b0000, (k == 5) ? 4'b0100 : 4'b0000, c0, o0);
            add(4'b0011, 4'b0000, 4'b0000, c0, o0);
        end
        add(4'b0011, 4'b0000, 4'b0100, 8'h30, 4'b0000);
        add(4'b0011, 4'b0000, 4'b0000, 8'h30, 4'b0000);
        run_table("ch2_sat");

        // Push and pop together at max
        add(4'b0111, 4'b0000, 4'b0000, 8'h30, 4'h0);
        add(4'b0111, 4'b0000, 4'b0000, 8'h30, 4'h0);
        add(4'b0111, 4'b0100, 4'b0000, 8'h30, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h30, 4'h0);
        add(4'b0011, 4'b0100, 4'b0000, 8'h20, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h20, 4'h0);
        run_table("push_pop_max");

        // Channel 3 to count 2, then asynchronous reset
        add(4'b1011, 4'b0000, 4'b0000, 8'h20, 4'h0);
        add(4'b1011, 4'b0000, 4'b0000, 8'h20, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h60, 4'h0);
        add(4'b0011, 4'b0000, 4'b0000, 8'h60, 4'h0);
        add(4'b1011, 4'b0000, 4'b0000, 8'h60, 4'h0);
        add(4'b1011, 4'b0000, 4'b0000, 8'h60, 4'h0);
        add(4'b1011, 4'b0000, 4'b0000, 8'hA0, 4'h0);
        run_table("ch3_fill");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset");

        // Random toggles against the reference model
        async_in = '0; ready = '0; clr = '0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        ra = '0;
        for (int c = 0; c < 4; c++) hold[c] = 2;
        for (int i = 0; i < 500; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    ra[c] = ~ra[c];
                    hold[c] = 2 + int'($urandom_range(0, 4));
                end
                hold[c]--;
                rr[c] = ($urandom_range(0, 2) == 0);
                rc[c] = ($urandom_range(0, 15) == 0);
            end
            step(ra, rr, rc, 1'b1, 8'h00, 4'h0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
